// File: rtl/fetch_unit_pkg.sv
// Shared constants and FIFO entry layout for the instruction fetch front-end.
package fetch_unit_pkg;

  localparam int unsigned PcIncr       = 4;
  localparam int unsigned AlignLowMask = 3;

  // A FIFO entry is {pc, inst}: the PC in the upper field, the instruction word in the lower.
  function automatic int unsigned entry_width(input int unsigned pc_w, input int unsigned inst_w);
    return pc_w + inst_w;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous show-ahead FIFO with flush; the head entry is visible whenever the FIFO is not empty.
module fetch_fifo #(
  parameter int unsigned depth     = 4,
  parameter int unsigned width     = 64,
  parameter int unsigned cnt_width = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [width-1:0]     wdata_i,
  output logic [width-1:0]     rdata_o,
  output logic [cnt_width-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = $clog2(depth);

  logic [width-1:0]     mem_q [depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == cnt_width'(depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + cnt_width'(do_push) - cnt_width'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited sequential prefetch into a show-ahead FIFO,
// with redirect flushing buffered words and discarding responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         pc_width   = 32,
  parameter logic [pc_width-1:0] pc_init    = '0,
  parameter int unsigned         inst_width = 32,
  parameter int unsigned         fifo_depth = 4,
  parameter int unsigned         cnt_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  i_raddr_valid,
  input  logic                  i_raddr_ready,
  output logic [pc_width-1:0]   i_raddr,
  input  logic                  i_rdata_valid,
  output logic                  i_rdata_ready,
  input  logic [inst_width-1:0] i_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [inst_width-1:0] inst,
  output logic [pc_width-1:0]   inst_pc,
  input  logic                  redirect,
  input  logic [pc_width-1:0]   redirect_pc
);

  localparam int unsigned         EntryWidth = entry_width(pc_width, inst_width);
  localparam logic [pc_width-1:0] PcStep     = pc_width'(PcIncr);
  localparam logic [pc_width-1:0] AlignMask  = ~pc_width'(AlignLowMask);

  logic [pc_width-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, raddr_q, raddr_d;
  logic [pc_width-1:0]   redirect_aligned;
  logic                  req_valid_q, req_valid_d, stale_q, stale_d;
  logic [cnt_width-1:0]  outstanding_q, outstanding_d, discard_q, discard_d;
  logic [cnt_width-1:0]  live_d, fifo_count, count_after;
  logic                  addr_hs, push, pop, fifo_full, fifo_empty;
  logic [EntryWidth-1:0] head_entry;

  assign redirect_aligned = redirect_pc & AlignMask;
  assign addr_hs          = req_valid_q && i_raddr_ready;
  assign push             = i_rdata_valid && (discard_q == '0);
  assign pop              = !fifo_empty && inst_ready;

  always_comb begin
    outstanding_d = outstanding_q + cnt_width'(addr_hs) - cnt_width'(i_rdata_valid);
    if (redirect) begin
      // Everything still owed by memory after this cycle belongs to the old stream.
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q + cnt_width'(stale_q && addr_hs)
                - cnt_width'(i_rdata_valid && (discard_q != '0));
    end
    live_d = outstanding_d - discard_d;

    fetch_pc_d = fetch_pc_q;
    if (addr_hs && !stale_q) fetch_pc_d = fetch_pc_q + PcStep;
    if (redirect)            fetch_pc_d = redirect_aligned;

    resp_pc_d = resp_pc_q;
    if (push)     resp_pc_d = resp_pc_q + PcStep;
    if (redirect) resp_pc_d = redirect_aligned;

    count_after = redirect ? '0 : fifo_count + cnt_width'(push) - cnt_width'(pop);

    req_valid_d = req_valid_q;
    raddr_d     = raddr_q;
    stale_d     = stale_q;
    if (req_valid_q && !i_raddr_ready) begin
      // A raised request must hold its address; a redirect only marks it stale.
      if (redirect) stale_d = 1'b1;
    end else begin
      req_valid_d = (int'(count_after) + int'(live_d)) < int'(fifo_depth);
      raddr_d     = fetch_pc_d;
      stale_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= pc_init;
      resp_pc_q     <= pc_init;
      raddr_q       <= pc_init;
      req_valid_q   <= 1'b0;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      raddr_q       <= raddr_d;
      req_valid_q   <= req_valid_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .depth     (fifo_depth),
    .width     (EntryWidth),
    .cnt_width (cnt_width)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({resp_pc_q, i_rdata}),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign i_raddr_valid = req_valid_q;
  assign i_raddr       = raddr_q;
  assign i_rdata_ready = 1'b1;
  assign inst_valid    = !fifo_empty;
  assign inst          = head_entry[inst_width-1:0];
  assign inst_pc       = head_entry[EntryWidth-1 -: pc_width];

  // Credit accounting must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !redirect));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model feeds responses, expected {pc, inst} entries
// are queued as live responses are driven and compared as the decoder side consumes them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_raddr_valid, i_raddr_ready;
  logic [31:0] i_raddr;
  logic        i_rdata_valid, i_rdata_ready;
  logic [31:0] i_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_raddr_valid (i_raddr_valid),
    .i_raddr_ready (i_raddr_ready),
    .i_raddr       (i_raddr),
    .i_rdata_valid (i_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .i_rdata       (i_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] sb_q[$];
  int          n_checks = 0;
  int          n_bad    = 0;
  int          cyc;
  int          lat;
  logic [31:0] exp_addr, stale_addr, cur_addr, first_pc;
  bit          tb_stale, cur_live, watch_first, got_first;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sampled at negedge: records the handshakes that complete at the coming posedge.
  task automatic observe();
    mreq_t       m;
    logic [63:0] e;
    if (i_raddr_valid && i_raddr_ready) begin
      m.addr = i_raddr;
      m.due  = cyc + lat;
      if (tb_stale) begin
        check("stale_addr", i_raddr, stale_addr);
        m.live   = 1'b0;
        tb_stale = 1'b0;
      end else begin
        check("req_addr", i_raddr, exp_addr);
        m.live   = 1'b1;
        exp_addr = exp_addr + 32'd4;
      end
      mem_q.push_back(m);
    end
    if (inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("inst_valid_unexpected", inst_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("inst", {inst_pc, inst}, e);
        if (watch_first) begin
          first_pc    = inst_pc;
          got_first   = 1'b1;
          watch_first = 1'b0;
        end
      end
    end
    if (i_rdata_valid && cur_live) sb_q.push_back({cur_addr, mem_word(cur_addr)});
    if (redirect) begin
      sb_q.delete();
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
      exp_addr = redirect_pc & ~32'd3;
      if (i_raddr_valid && !i_raddr_ready && !tb_stale) begin
        tb_stale   = 1'b1;
        stale_addr = i_raddr;
      end
      watch_first = 1'b1;
      got_first   = 1'b0;
    end
  endtask

  task automatic drive_mem();
    mreq_t r;
    i_rdata_valid = 1'b0;
    cur_live      = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r             = mem_q.pop_front();
      i_rdata_valid = 1'b1;
      i_rdata       = mem_word(r.addr);
      cur_addr      = r.addr;
      cur_live      = r.live;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  // Memory side is reset together with the DUT.
  task automatic do_reset();
    rst           = 1'b0;
    redirect      = 1'b0;
    i_rdata_valid = 1'b0;
    cur_live      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_raddr_valid", i_raddr_valid, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    mem_q.delete();
    sb_q.delete();
    exp_addr    = 32'h0;
    tb_stale    = 1'b0;
    watch_first = 1'b0;
    got_first   = 1'b0;
    rst         = 1'b1;
    cyc         = 0;
  endtask

  initial begin
    inst_ready    = 1'b1;
    i_raddr_ready = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    i_rdata       = 32'h0;
    lat           = 1;
    do_reset();
    check("rdata_ready", i_rdata_ready, 1'b1);

    // Latency and steady-state streaming.
    check("c0_valid", i_raddr_valid, 1'b0);
    tick();
    check("c1_valid", i_raddr_valid, 1'b1);
    check("c1_addr", i_raddr, 32'h0);
    tick();
    check("c2_inst_valid", inst_valid, 1'b0);
    tick();
    check("c3_inst_valid", inst_valid, 1'b1);
    check("c3_pc", inst_pc, 32'h0);
    tick();
    check("c4_inst_valid", inst_valid, 1'b1);
    check("c4_pc", inst_pc, 32'h4);
    repeat (6) tick();

    // Decode stall: credit caps the prefetch at the FIFO depth.
    inst_ready = 1'b0;
    repeat (10) tick();
    check("bp_raddr_valid", i_raddr_valid, 1'b0);
    check("bp_inst_valid", inst_valid, 1'b1);
    check("bp_fifo_entries", sb_q.size(), 4);
    check("bp_in_flight", mem_q.size(), 0);
    inst_ready = 1'b1;
    repeat (12) tick();

    // Address channel stall with 8 pending.
    do_reset();
    repeat (3) tick();
    i_raddr_ready = 1'b0;
    repeat (3) begin
      check("stall_addr", i_raddr, 32'h8);
      check("stall_valid", i_raddr_valid, 1'b1);
      tick();
    end
    i_raddr_ready = 1'b1;
    check("stall_addr_last", i_raddr, 32'h8);
    tick();
    check("after_stall_addr", i_raddr, 32'hc);
    check("after_stall_valid", i_raddr_valid, 1'b1);
    repeat (6) tick();

    // Redirect with slow memory and responses in flight.
    lat = 3;
    repeat (10) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("r1_inst_valid", inst_valid, 1'b0);
    check("r1_addr", i_raddr, 32'h100);
    check("r1_valid", i_raddr_valid, 1'b1);
    repeat (14) tick();
    check("r_first_seen", got_first, 1'b1);
    check("r_first_pc", first_pc, 32'h100);

    // Redirect while 0x20 is pending and unaccepted.
    lat = 1;
    do_reset();
    repeat (9) tick();
    check("p5_addr", i_raddr, 32'h20);
    i_raddr_ready = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 32'h200;
    tick();
    redirect = 1'b0;
    check("p5_stale_hold", i_raddr, 32'h20);
    check("p5_stale_valid", i_raddr_valid, 1'b1);
    tick();
    i_raddr_ready = 1'b1;
    check("p5_stale_hold2", i_raddr, 32'h20);
    tick();
    check("p5_new_addr", i_raddr, 32'h200);
    check("p5_new_valid", i_raddr_valid, 1'b1);
    repeat (8) tick();
    check("p5_first_seen", got_first, 1'b1);
    check("p5_first_pc", first_pc, 32'h200);

    // Unaligned redirect colliding with a pop and a push.
    repeat (4) tick();
    check("p6_pre_inst_valid", inst_valid, 1'b1);
    check("p6_pre_rdata_valid", i_rdata_valid, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check("p6_inst_valid", inst_valid, 1'b0);
    check("p6_addr", i_raddr, 32'h100);
    check("p6_valid", i_raddr_valid, 1'b1);
    repeat (5) tick();
    check("p6_first_seen", got_first, 1'b1);
    check("p6_first_pc", first_pc, 32'h100);

    // Reset pulsed mid-stream.
    do_reset();
    watch_first = 1'b1;
    tick();
    check("mr_addr", i_raddr, 32'h0);
    check("mr_valid", i_raddr_valid, 1'b1);
    repeat (5) tick();
    check("mr_first_seen", got_first, 1'b1);
    check("mr_first_pc", first_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
